// File: rtl/jk_ctrl_pkg.sv
// ============================================================================
// jk_ctrl_pkg: {j,k} command encodings shared by the jkff command stage
// rev 1.0
// ============================================================================
`default_nettype none

package jk_ctrl_pkg;

   typedef enum logic [1:0] {
      JK_HOLD = 2'b00,
      JK_CLR  = 2'b01,
      JK_SET  = 2'b10,
      JK_TGL  = 2'b11
   } jk_cmd_e;

   localparam int CMD_CNT_W = 8;

endpackage : jk_ctrl_pkg

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// btn_debounce: 2-flop synchronizer, stability counter and press strobe
// rev 1.0
// ============================================================================
`default_nettype none

module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic press
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             deb_q, deb_d;
   logic             deb_dly_q, deb_dly_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;

   always_comb begin
      sync1_d   = raw;
      sync2_d   = sync1_q;
      deb_d     = deb_q;
      cnt_d     = '0;
      deb_dly_d = deb_q;
      // the counter only runs while the synced level disagrees; any agreement restarts it
      if (sync2_q != deb_q) begin
         if (cnt_q == CNT_LAST) begin
            deb_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      press_d = deb_q & ~deb_dly_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         deb_q     <= 1'b0;
         deb_dly_q <= 1'b0;
         cnt_q     <= '0;
         press_q   <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         deb_q     <= deb_d;
         deb_dly_q <= deb_dly_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
      end
   end

   assign press = press_q;

endmodule : btn_debounce

`default_nettype wire

// File: rtl/jk_button_ctrl.sv
// ============================================================================
// jk_button_ctrl: debounced set/clear/toggle buttons to one-cycle jkff commands
// rev 1.0
// ============================================================================
`default_nettype none

module jk_button_ctrl
   import jk_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 btn_set,
   input  logic                 btn_clr,
   input  logic                 btn_tgl,
   output logic                 j,
   output logic                 k,
   output logic                 conflict,
   output logic [CMD_CNT_W-1:0] cmd_count
);

   logic press_set, press_clr, press_tgl;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_set (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_set),
      .press (press_set)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_clr (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_clr),
      .press (press_clr)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_tgl (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_tgl),
      .press (press_tgl)
   );

   jk_cmd_e              cmd_q, cmd_d;
   logic                 conflict_q, conflict_d;
   logic [CMD_CNT_W-1:0] cmd_count_q, cmd_count_d;

   always_comb begin
      cmd_d       = JK_HOLD;
      conflict_d  = 1'b0;
      cmd_count_d = cmd_count_q;
      // toggle dominates; set+clr alone is ambiguous and is flagged instead of issued
      if (press_tgl) begin
         cmd_d = JK_TGL;
      end else if (press_set && press_clr) begin
         conflict_d = 1'b1;
      end else if (press_set) begin
         cmd_d = JK_SET;
      end else if (press_clr) begin
         cmd_d = JK_CLR;
      end
      if (cmd_d != JK_HOLD) begin
         cmd_count_d = cmd_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q       <= JK_HOLD;
         conflict_q  <= 1'b0;
         cmd_count_q <= '0;
      end else begin
         cmd_q       <= cmd_d;
         conflict_q  <= conflict_d;
         cmd_count_q <= cmd_count_d;
      end
   end

   assign j         = cmd_q[1];
   assign k         = cmd_q[0];
   assign conflict  = conflict_q;
   assign cmd_count = cmd_count_q;

endmodule : jk_button_ctrl

`default_nettype wire

// File: doc/jk_button_ctrl.md
# jk_button_ctrl

Upstream command stage for the team's JK flip-flop (`jkff`). It takes three raw, asynchronous push-button inputs (set, clear, toggle), synchronizes and debounces each one, and detects press edges. Each press becomes a single-cycle registered `{j,k}` command that drives `jkff` directly. It also reports command conflicts and keeps a running count of issued commands.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronized input must differ from its debounced state before that state flips; legal range 2..65535.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: width of the debounce counter; derived, do not override.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_set`  in  1  raw set button, asynchronous to `clk`, active-high.
- `btn_clr`  in  1  raw clear button, asynchronous, active-high.
- `btn_tgl`  in  1  raw toggle button, asynchronous, active-high.
- `j`  out  1  registered J command to `jkff`.
- `k`  out  1  registered K command to `jkff`.
- `conflict`  out  1  one-cycle pulse when set and clear presses coincide with no toggle press.
- `cmd_count`  out  8  number of non-hold commands issued; wraps.

## Operation
- Reset (`rst_n`=0, asynchronous) clears everything: synchronizers, debounced states, counters, `j`, `k`, `conflict` and `cmd_count` all go to 0.
- Synchronization: each button passes through a 2-flop synchronizer.
- Debounce, per button:
  - When synced ≠ debounced, the counter increments.
  - When synced = debounced, the counter clears to 0.
  - When the counter equals `DEBOUNCE_CYCLES-1` and the inputs still differ, the debounced state flips on that edge and the counter clears.
- Press event: a 0→1 transition of the debounced state, registered as a one-cycle `press_*` strobe. A 1→0 transition (release) generates no event.
- Arbitration, on the strobes in a given cycle:
  - tgl present → `{j,k}`=11, regardless of set or clr.
  - set only → 10.
  - clr only → 01.
  - set and clr without tgl → 00, and `conflict`=1 for one cycle.
  - no strobe → 00.
- Output rules:
  - `j` and `k` are registered.
  - A command is high for exactly one cycle, then returns to 00 (hold).
  - Held buttons do not repeat.
- `cmd_count` increments by 1 in the cycle a non-00 command is registered. It wraps 255→0. A conflict does not count.
- A button held high through reset release is debounced and produces one press after the normal latency.
- A glitch shorter than `DEBOUNCE_CYCLES` synced cycles produces no event.

## Timing
- Latency: the input changes between edges, and edge 1 is the first sampling edge.
  - The debounced state flips at edge `DEBOUNCE_CYCLES+2`.
  - The strobe is high after edge `DEBOUNCE_CYCLES+3`.
  - `j`/`k` are high during the cycle following edge `DEBOUNCE_CYCLES+4`.
  - With the default of 4, `j`/`k` are high after edge 8.
- `cmd_count` updates on the same edge that registers the command.
- `conflict` aligns with the 00 command cycle it flags.
- There is no ready/valid handshake: `jkff` samples every edge, and this block guarantees 00 on every non-command cycle.
- Assertion of `rst_n` mid-debounce or mid-pulse aborts immediately: outputs read 0 asynchronously and no partial command survives.

## Structure
- Package `jk_ctrl_pkg` holds the command encodings: `JK_HOLD`=2'b00, `JK_CLR`=2'b01, `JK_SET`=2'b10, `JK_TGL`=2'b11.
- Sub-module `btn_debounce` (parameter `DEBOUNCE_CYCLES`; ports `clk`, `rst_n`, `raw`, `press`) contains the synchronizer, debounce counter and rising-edge strobe. It is instantiated 3 times.
- The top level contains only the arbitration, the output registers and `cmd_count`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Reset: hold `rst_n`=0 with all buttons 0, then release → `j`,`k`,`conflict`=0 and `cmd_count`=0; assert `rst_n` mid-cycle → outputs clear without waiting for `clk`.
- Single set press: `btn_set`=1 held 20 cycles → exactly one cycle of `{j,k}`=10 after edge 8, `cmd_count`=1, and `jkff` q=1.
- Glitch rejection: `btn_clr` pulses high for 3 cycles → `{j,k}` stays 00 and `cmd_count` is unchanged.
- Simultaneous presses:
  - set and clr rise on the same cycle → one `conflict` pulse, `{j,k}`=00, count unchanged.
  - tgl rises on the same cycle as set → a single 11, count+1.
- Wrap: issue 256 toggle presses → `cmd_count` returns to 0 and the `jkff` q ends at its initial value.
- Reset mid-debounce: `btn_tgl` rises, `rst_n` pulses low at edge 4, button still held → the press still emits 11 once, 8 edges after reset release.
